// File: rtl/pcie_rx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pcie_rx_pkg : shared PIPE RX framing constants and state types   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pcie_rx_pkg;

  localparam logic [1:0] SH_OS   = 2'b01;
  localparam logic [1:0] SH_DATA = 2'b10;

  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] EIEOS_EVEN = 8'h00;
  localparam logic [7:0] EIEOS_ODD  = 8'hFF;

  typedef enum logic [0:0] {
    WAIT_START = 1'b0,
    IN_BLOCK   = 1'b1
  } blk_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_block_tracker_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rx_block_tracker_if : PIPE RX input and aligned output bundle    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface rx_block_tracker_if #(
  parameter int data_width         = 8,
  parameter int symbol_count_width = 4
);

  logic                          GEN;
  logic                          RxValid;
  logic                          RxStartBlock;
  logic [1:0]                    RxSyncHeader;
  logic                          RxDataK;
  logic [data_width-1:0]         PIPE_Data_In;

  logic [data_width-1:0]         PIPE_Data;
  logic                          RX_Data_Valid;
  logic [symbol_count_width-1:0] count;
  logic                          SyncHeader;
  logic                          GEN_Out;
  logic                          block_err;
  logic                          eieos_det;

  modport master (
    output GEN, RxValid, RxStartBlock, RxSyncHeader, RxDataK, PIPE_Data_In,
    input  PIPE_Data, RX_Data_Valid, count, SyncHeader, GEN_Out, block_err, eieos_det
  );

  modport slave (
    input  GEN, RxValid, RxStartBlock, RxSyncHeader, RxDataK, PIPE_Data_In,
    output PIPE_Data, RX_Data_Valid, count, SyncHeader, GEN_Out, block_err, eieos_det
  );

endinterface
`default_nettype wire

// File: rtl/eieos_matcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | eieos_matcher : running 00h/FFh match over an emitted OS block   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module eieos_matcher
  import pcie_rx_pkg::*;
#(
  parameter int data_width         = 8,
  parameter int symbol_count_width = 4
) (
  input  wire logic                          CLK,
  input  wire logic                          RST_L,
  input  wire logic                          clr,
  input  wire logic                          emit,
  input  wire logic                          is_os,
  input  wire logic [symbol_count_width-1:0] sym_count,
  input  wire logic [data_width-1:0]         sym_data,
  output logic                               eieos_det
);

  localparam logic [symbol_count_width-1:0] C_LAST = '1;

  logic match_q, match_d;
  logic det_q, det_d;
  logic sym_ok;

  always_comb begin
    sym_ok  = sym_count[0] ? (sym_data == data_width'(EIEOS_ODD))
                           : (sym_data == data_width'(EIEOS_EVEN));
    match_d = match_q;
    det_d   = 1'b0;
    if (clr) begin
      match_d = 1'b0;
    end else if (emit) begin
      // symbol 0 restarts the flag; later symbols can only clear it
      if (sym_count == '0) match_d = is_os && sym_ok;
      else                 match_d = match_q && sym_ok;
      det_d = is_os && (sym_count == C_LAST) && match_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      match_q <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      match_q <= match_d;
      det_q   <= det_d;
    end
  end

  assign eieos_det = det_q;

endmodule
`default_nettype wire

// File: rtl/rx_block_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rx_block_tracker : PIPE RX block framing ahead of descrambler    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rx_block_tracker
  import pcie_rx_pkg::*;
#(
  parameter int data_width         = 8,
  parameter int symbol_count_width = 4
) (
  input  wire logic          CLK,
  input  wire logic          RST_L,
  rx_block_tracker_if.slave  rx_if
);

  localparam logic [symbol_count_width-1:0] C_LAST = '1;
  localparam logic [symbol_count_width-1:0] C_ONE  = symbol_count_width'(1);

  blk_state_t                    state_q, state_d;
  logic [symbol_count_width-1:0] count_q, count_d;
  logic [data_width-1:0]         pipe_data_q, pipe_data_d;
  logic                          rx_valid_q, rx_valid_d;
  logic                          sync_hdr_q, sync_hdr_d;
  logic                          gen_q, gen_d;
  logic                          block_err_q, block_err_d;

  logic gen_change;
  logic hdr_ok;
  logic emit_g3;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pipe_data_d = pipe_data_q;
    rx_valid_d  = 1'b0;
    sync_hdr_d  = sync_hdr_q;
    gen_d       = rx_if.GEN;
    block_err_d = 1'b0;
    emit_g3     = 1'b0;
    gen_change  = (rx_if.GEN != gen_q);
    hdr_ok      = (rx_if.RxSyncHeader == SH_OS) || (rx_if.RxSyncHeader == SH_DATA);

    if (gen_change) begin
      state_d    = WAIT_START;
      count_d    = '0;
      sync_hdr_d = 1'b0;
    end else if (rx_if.RxValid) begin
      if (!rx_if.GEN) begin
        state_d     = WAIT_START;
        sync_hdr_d  = 1'b0;
        rx_valid_d  = 1'b1;
        pipe_data_d = rx_if.PIPE_Data_In;
        if (rx_if.RxDataK && (rx_if.PIPE_Data_In == data_width'(COM)))
          count_d = '0;
        else if (count_q != C_LAST)
          count_d = count_q + C_ONE;
      end else if (rx_if.RxStartBlock) begin
        // a start inside a block is an error even when the new header is good
        block_err_d = (state_q == IN_BLOCK) || !hdr_ok;
        if (hdr_ok) begin
          state_d     = IN_BLOCK;
          count_d     = '0;
          sync_hdr_d  = (rx_if.RxSyncHeader == SH_OS);
          rx_valid_d  = 1'b1;
          pipe_data_d = rx_if.PIPE_Data_In;
          emit_g3     = 1'b1;
        end else begin
          state_d = WAIT_START;
        end
      end else if (state_q == IN_BLOCK) begin
        count_d     = count_q + C_ONE;
        rx_valid_d  = 1'b1;
        pipe_data_d = rx_if.PIPE_Data_In;
        emit_g3     = 1'b1;
        if (count_d == C_LAST) state_d = WAIT_START;
      end else begin
        block_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q     <= WAIT_START;
      count_q     <= '0;
      pipe_data_q <= '0;
      rx_valid_q  <= 1'b0;
      sync_hdr_q  <= 1'b0;
      gen_q       <= 1'b0;
      block_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pipe_data_q <= pipe_data_d;
      rx_valid_q  <= rx_valid_d;
      sync_hdr_q  <= sync_hdr_d;
      gen_q       <= gen_d;
      block_err_q <= block_err_d;
    end
  end

  eieos_matcher #(
    .data_width         (data_width),
    .symbol_count_width (symbol_count_width)
  ) u_eieos_matcher (
    .CLK       (CLK),
    .RST_L     (RST_L),
    .clr       (gen_change),
    .emit      (emit_g3),
    .is_os     (sync_hdr_d),
    .sym_count (count_d),
    .sym_data  (rx_if.PIPE_Data_In),
    .eieos_det (rx_if.eieos_det)
  );

  assign rx_if.PIPE_Data     = pipe_data_q;
  assign rx_if.RX_Data_Valid = rx_valid_q;
  assign rx_if.count         = count_q;
  assign rx_if.SyncHeader    = sync_hdr_q;
  assign rx_if.GEN_Out       = gen_q;
  assign rx_if.block_err     = block_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_block_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rx_block_tracker : directed self-checking bench               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_rx_block_tracker;

  logic clk;
  logic rst_l;
  int   checks   = 0;
  int   failures = 0;

  rx_block_tracker_if #(.data_width(8), .symbol_count_width(4)) bus ();

  rx_block_tracker #(.data_width(8), .symbol_count_width(4)) dut (
    .CLK   (clk),
    .RST_L (rst_l),
    .rx_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one input cycle, then sample 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic s, input logic [1:0] h,
                     input logic k, input logic [7:0] d);
    bus.RxValid      = v;
    bus.RxStartBlock = s;
    bus.RxSyncHeader = h;
    bus.RxDataK      = k;
    bus.PIPE_Data_In = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input int cnt, input logic sh,
                         input logic err, input logic det);
    chk({tag, "_valid"}, 32'(bus.RX_Data_Valid), 32'(v));
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    chk({tag, "_sh"},    32'(bus.SyncHeader), 32'(sh));
    chk({tag, "_err"},   32'(bus.block_err), 32'(err));
    chk({tag, "_eieos"}, 32'(bus.eieos_det), 32'(det));
  endtask

  initial begin
    rst_l = 1'b0;
    bus.GEN = 1'b1;
    bus.RxValid = 1'b0;
    bus.RxStartBlock = 1'b0;
    bus.RxSyncHeader = 2'b00;
    bus.RxDataK = 1'b0;
    bus.PIPE_Data_In = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(bus.PIPE_Data), 32'h0);
    chk("rst_gen", 32'(bus.GEN_Out), 32'h0);
    chk_out("rst", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    #4 rst_l = 1'b1;
    @(negedge clk);
    cyc(0, 0, 2'b00, 0, 8'h00);
    chk("gen_out_g3", 32'(bus.GEN_Out), 32'h1);
    cyc(0, 0, 2'b00, 0, 8'h00);

    // Gen3 data block 00h..0Fh with one gap after symbol 5
    for (int i = 0; i < 16; i++) begin
      cyc(1, i == 0, 2'b10, 0, 8'(i));
      chk("d_data", 32'(bus.PIPE_Data), 32'(i));
      chk_out("d", 1'b1, i, 1'b0, 1'b0, 1'b0);
      if (i == 5) begin
        cyc(0, 0, 2'b00, 0, 8'h77);
        chk("gap_valid", 32'(bus.RX_Data_Valid), 32'h0);
        chk("gap_count", 32'(bus.count), 32'd5);
      end
    end

    // Back-to-back EIEOS ordered set
    for (int i = 0; i < 16; i++) begin
      cyc(1, i == 0, 2'b01, 0, (i % 2 == 0) ? 8'h00 : 8'hFF);
      chk_out("eie", 1'b1, i, 1'b1, 1'b0, i == 15);
    end

    // Corrupted EIEOS: symbol 6 = 01h
    for (int i = 0; i < 16; i++) begin
      cyc(1, i == 0, 2'b01, 0, (i == 6) ? 8'h01 : ((i % 2 == 0) ? 8'h00 : 8'hFF));
      chk_out("bad_eie", 1'b1, i, 1'b1, 1'b0, 1'b0);
    end

    // Start inside a block at count 7
    for (int i = 0; i < 8; i++) cyc(1, i == 0, 2'b10, 0, 8'(8'h30 + i));
    chk("pre_restart_count", 32'(bus.count), 32'd7);
    cyc(1, 1, 2'b01, 0, 8'hAA);
    chk_out("restart", 1'b1, 0, 1'b1, 1'b1, 1'b0);
    chk("restart_data", 32'(bus.PIPE_Data), 32'hAA);

    // Illegal header from inside a block, then a symbol with no start
    cyc(1, 1, 2'b11, 0, 8'h11);
    chk("hdr11_err", 32'(bus.block_err), 32'h1);
    chk("hdr11_valid", 32'(bus.RX_Data_Valid), 32'h0);
    cyc(1, 0, 2'b00, 0, 8'h22);
    chk("nostart_err", 32'(bus.block_err), 32'h1);
    chk("nostart_valid", 32'(bus.RX_Data_Valid), 32'h0);
    cyc(0, 0, 2'b00, 0, 8'h00);
    chk("idle_err", 32'(bus.block_err), 32'h0);
    cyc(1, 1, 2'b00, 0, 8'h00);
    chk("hdr00_err", 32'(bus.block_err), 32'h1);
    chk("hdr00_valid", 32'(bus.RX_Data_Valid), 32'h0);

    // Gen1/2: COM, 20 data symbols with stray start/header, COM, D-coded BCh
    bus.GEN = 1'b0;
    cyc(0, 0, 2'b00, 0, 8'h00);
    chk("gen_out_g1", 32'(bus.GEN_Out), 32'h0);
    chk("g1_sh", 32'(bus.SyncHeader), 32'h0);
    chk("g1_err", 32'(bus.block_err), 32'h0);
    cyc(1, 0, 2'b00, 1, 8'hBC);
    chk_out("com", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("com_data", 32'(bus.PIPE_Data), 32'hBC);
    for (int i = 0; i < 20; i++) begin
      cyc(1, i == 3, (i == 3) ? 2'b11 : 2'b00, 0, 8'(8'h40 + i));
      chk_out("g1", 1'b1, (i < 15) ? i + 1 : 15, 1'b0, 1'b0, 1'b0);
      chk("g1_data", 32'(bus.PIPE_Data), 32'(8'h40 + i));
    end
    cyc(1, 0, 2'b00, 1, 8'hBC);
    chk("com2_count", 32'(bus.count), 32'd0);
    cyc(1, 0, 2'b00, 0, 8'hBC);
    chk("dbc_count", 32'(bus.count), 32'd1);
    cyc(1, 0, 2'b00, 1, 8'hF7);
    chk("k_other_count", 32'(bus.count), 32'd2);

    // Back to Gen3, reset at count 9 with gaps
    bus.GEN = 1'b1;
    cyc(0, 0, 2'b00, 0, 8'h00);
    chk("gen_out_g3b", 32'(bus.GEN_Out), 32'h1);
    chk("g3b_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, i == 0, 2'b10, 0, 8'(8'h60 + i));
      if (i == 4) cyc(0, 0, 2'b00, 0, 8'h00);
    end
    chk("pre_rst_count", 32'(bus.count), 32'd9);
    chk("pre_rst_valid", 32'(bus.RX_Data_Valid), 32'h1);
    rst_l = 1'b0;
    #1;
    chk("arst_data", 32'(bus.PIPE_Data), 32'h0);
    chk("arst_gen", 32'(bus.GEN_Out), 32'h0);
    chk_out("arst", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    bus.RxValid = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    cyc(0, 0, 2'b00, 0, 8'h00);
    cyc(0, 0, 2'b00, 0, 8'h00);
    cyc(1, 1, 2'b01, 0, 8'h00);
    chk_out("post_rst", 1'b1, 0, 1'b1, 1'b0, 1'b0);
    cyc(1, 0, 2'b00, 0, 8'hFF);
    chk_out("post_rst1", 1'b1, 1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_block_tracker.md
# rx_block_tracker

Receive-side block framing stage placed directly upstream of the descrambler controller. Consumes the PIPE RX byte stream, start-block strobe and sync header from the PHY. Produces a one-cycle-delayed, block-aligned stream with the symbol index (`count`), block type (`SyncHeader`) and `GEN` qualifier the descrambler stage expects. Also flags malformed 128b/130b framing and detects a complete 8.0 GT/s EIEOS.

## Interface
Parameters:
- `data_width`, 8: symbol width.
- `symbol_count_width`, 4: width of the symbol index (16-symbol blocks).

Ports:
- `CLK`  in  1  clock.
- `RST_L`  in  1  reset, asynchronous, active-low.
- `GEN`  in  1  0 = Gen1/2 (8b/10b), 1 = Gen3+ (128b/130b); static while traffic flows.
- `RxValid`  in  1  PIPE symbol valid.
- `RxStartBlock`  in  1  first symbol of a 128b/130b block (Gen3+ only).
- `RxSyncHeader`  in  2  sync header, sampled only with `RxStartBlock`.
- `RxDataK`  in  1  K-character flag (Gen1/2 only).
- `PIPE_Data_In`  in  data_width  received symbol.
- `PIPE_Data`  out  data_width  aligned symbol to descrambler.
- `RX_Data_Valid`  out  1  output symbol valid.
- `count`  out  symbol_count_width  symbol index within block/ordered set.
- `SyncHeader`  out  1  1 = ordered-set block (01b), 0 = data block (10b).
- `GEN_Out`  out  1  registered copy of `GEN`.
- `block_err`  out  1  one-cycle framing-error pulse.
- `eieos_det`  out  1  one-cycle pulse with symbol 15 of a valid EIEOS block.

## Operation
Gen3+ FSM, states `WAIT_START` and `IN_BLOCK`:
- `WAIT_START`, valid with start, header 01b/10b: latch header, emit symbol with count 0, go to `IN_BLOCK`.
- `WAIT_START`, valid with start, header 00b/11b: pulse `block_err`, drop the symbol, stay in `WAIT_START`.
- `WAIT_START`, valid without start: pulse `block_err`, drop the symbol.
- `IN_BLOCK`, valid without start: emit the symbol with count+1. After emitting count 15, return to `WAIT_START`.
- `IN_BLOCK`, valid with start (count ≠ 15): pulse `block_err` and restart the block. The symbol is treated exactly as in `WAIT_START` with start.

Gen1/2:
- No FSM, `SyncHeader` held 0.
- `RxDataK`=1 with `PIPE_Data_In`=BCh (COM) loads count 0.
- Any other valid symbol increments count, saturating at 15.
- Every valid symbol is forwarded.
- `RxStartBlock`/`RxSyncHeader` ignored.

EIEOS check (Gen3+, OS block only):
- Running match flag set at symbol 0.
- Flag cleared on any even symbol ≠ 00h or odd symbol ≠ FFh.
- `eieos_det` asserted together with emitted symbol 15 if the flag survives.

General:
- `RxValid`=0: state, count and flags hold; `RX_Data_Valid`=0.
- `GEN` change: FSM forced to `WAIT_START`, count cleared, no error pulse.

## Timing
- All outputs registered; latency exactly 1 cycle from input symbol to `PIPE_Data`/`count`/`SyncHeader`/`RX_Data_Valid`.
- `block_err` appears in the cycle the offending symbol would have been emitted.
- Reset values: `PIPE_Data`=0, `RX_Data_Valid`=0, `count`=0, `SyncHeader`=0, `GEN_Out`=0, `block_err`=0, `eieos_det`=0, FSM=`WAIT_START`, match flag=0.
- Reset mid-block discards the partial block; the first post-reset Gen3 symbol must carry `RxStartBlock`.
- Back-to-back blocks: start at the cycle after symbol 15 is accepted; gap cycles (`RxValid`=0) allowed anywhere.
- Count arithmetic is unsigned, `symbol_count_width` bits; wraps 15→0 only via a new block (Gen3) or COM (Gen1/2).
- No backpressure; downstream always accepts.

## Structure
- Shared package `pcie_rx_pkg`:
  - `SH_OS`=2'b01, `SH_DATA`=2'b10.
  - `COM`=8'hBC.
  - `EIEOS_EVEN`=8'h00, `EIEOS_ODD`=8'hFF.
  - FSM state enum `blk_state_t`.
- Optional sub-module `eieos_matcher`: match flag plus `eieos_det` register, driven by count, data, valid and SyncHeader.

## Test plan
- Gen3, start with header 10b, symbols 00h..0Fh → 1 cycle later `count` 0..15, `SyncHeader`=0, `RX_Data_Valid`=1 each, no error.
- Gen3 OS block, symbols 00h/FFh alternating → `SyncHeader`=1, `eieos_det`=1 only with count 15; repeat with symbol 6=01h → no `eieos_det`.
- Gen3, `RxStartBlock` at count 7 with header 01b → `block_err` pulse, next output count=0, `SyncHeader`=1.
- Gen3, header 11b → `block_err`, `RX_Data_Valid`=0; following symbol without start → second `block_err`.
- Gen1/2, K BCh then 20 D symbols → count 0,1..15, then held 15; next COM → count 0.
- Assert `RST_L` at count 9 with `RxValid` gaps → all outputs 0 immediately; next start-block accepted as count 0.
